// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch controller.
// Optional misaligned-redirect trapping is enabled with FETCH_ALIGN_TRAP_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_STALL  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_3100;
    localparam logic [31:0] INSTR_BYTES          = 32'd4;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential increment or taken-branch target.
// With FETCH_ALIGN_TRAP_EN a misaligned target becomes TRAP_VECTOR plus a trap flag.
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
`ifdef FETCH_ALIGN_TRAP_EN
    , parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT
`endif
) (
    input  logic [31:0] pc,
    input  logic        redirect,
    input  logic [31:0] br_pc,
    input  logic [31:0] immediate_value,
    output logic [31:0] next_pc,
    output logic        trap_flag
);

    logic [31:0] seq_pc;
    logic [31:0] target;
    logic [31:0] redirect_pc;

    always_comb begin
        // The adders wrap naturally modulo 2^32.
        seq_pc = pc + INSTR_BYTES;
        target = br_pc + immediate_value;
`ifdef FETCH_ALIGN_TRAP_EN
        trap_flag   = redirect && (target[1:0] != 2'b00);
        redirect_pc = (target[1:0] != 2'b00) ? TRAP_VECTOR : target;
`else
        trap_flag   = 1'b0;
        redirect_pc = target & ~(INSTR_BYTES - 32'd1);
`endif
        next_pc = redirect ? redirect_pc : seq_pc;
    end

endmodule

// File: rtl/fetch_controller.sv
// PC sequencing and single-outstanding instruction fetch with decode backpressure.
// Optional macro FETCH_ALIGN_TRAP_EN redirects misaligned branch targets to TRAP_VECTOR.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
`ifdef FETCH_ALIGN_TRAP_EN
    , parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT
`endif
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        br_valid,
    input  logic        zero,
    input  logic [31:0] br_pc,
    input  logic [31:0] immediate_value,
    input  logic        halt,
    output logic        halted,
    output logic        trap,
    output logic [1:0]  dbg_state
);

    // Handshakes: a fetch completes in any cycle with imem_req && imem_ack, and
    // imem_req/imem_addr stay stable until then; an instruction transfers to
    // decode in any cycle with instr_valid && instr_ready.
    fetch_state_e state, state_nxt;

    logic [31:0] pc;
    logic [31:0] drain_addr;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    logic        redirect;
    logic        accept;
    logic        pop;
    logic        slot_free;
    logic        fetch_ok;
    logic [31:0] next_pc;
    logic        trap_flag;

    assign redirect  = br_valid && zero;
    assign pop       = instr_valid && instr_ready;
    assign slot_free = !instr_valid || instr_ready;
    assign accept    = (state == ST_FETCH) && imem_ack && !redirect;
    assign fetch_ok  = slot_free && !skid_valid;

    assign imem_req  = rst && ((state == ST_FETCH) || (state == ST_DRAIN));
    assign imem_addr = (state == ST_DRAIN) ? drain_addr : pc;
    assign halted    = (state == ST_HALTED);
    assign dbg_state = state;

    next_pc_calc #(
        .RESET_VECTOR   (RESET_VECTOR)
`ifdef FETCH_ALIGN_TRAP_EN
        , .TRAP_VECTOR  (TRAP_VECTOR)
`endif
    ) u_next_pc (
        .pc              (pc),
        .redirect        (redirect),
        .br_pc           (br_pc),
        .immediate_value (immediate_value),
        .next_pc         (next_pc),
        .trap_flag       (trap_flag)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: begin
                if (imem_ack) begin
                    if (halt)
                        state_nxt = ST_HALTED;
                    else if (redirect || slot_free)
                        state_nxt = ST_FETCH;
                    else
                        state_nxt = ST_STALL;
                end else if (redirect) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_STALL: begin
                if (halt)
                    state_nxt = ST_HALTED;
                else if (redirect || instr_ready)
                    state_nxt = ST_FETCH;
            end
            ST_DRAIN: begin
                if (imem_ack)
                    state_nxt = halt ? ST_HALTED : ST_FETCH;
            end
            ST_HALTED: begin
                if (!halt)
                    state_nxt = fetch_ok ? ST_FETCH : ST_STALL;
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    // A word acked while decode is blocked lands in the skid entry, so the
    // in-flight fetch is never lost; FETCH is only entered with the skid empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_FETCH;
            pc          <= RESET_VECTOR;
            drain_addr  <= RESET_VECTOR;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            skid_valid  <= 1'b0;
            skid_instr  <= 32'h0;
            skid_pc     <= 32'h0;
            trap        <= 1'b0;
        end else begin
            state <= state_nxt;
            trap  <= trap_flag;
            if (redirect || accept)
                pc <= next_pc;
            if ((state == ST_FETCH) && !imem_ack && redirect)
                drain_addr <= pc;

            if (redirect && (state != ST_HALTED)) begin
                instr_valid <= 1'b0;
                skid_valid  <= 1'b0;
            end else if (pop) begin
                if (skid_valid) begin
                    instr      <= skid_instr;
                    instr_pc   <= skid_pc;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    instr    <= imem_rdata;
                    instr_pc <= pc;
                end else begin
                    instr_valid <= 1'b0;
                end
            end else if (accept) begin
                if (!instr_valid) begin
                    instr       <= imem_rdata;
                    instr_pc    <= pc;
                    instr_valid <= 1'b1;
                end else begin
                    skid_instr <= imem_rdata;
                    skid_pc    <= pc;
                    skid_valid <= 1'b1;
                end
            end
        end
    end

endmodule
